// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and default sizing.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GUARD = 2'd2
  } spi_state_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_GUARD   = 2;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: divides clk by 2*CLK_DIV while enabled and flags each SCLK edge.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap       = en && (div_cnt == DIV_LAST);
  assign rise_pulse = wrap && !sclk;
  assign fall_pulse = wrap && sclk;

  // Disabled means parked: divider at zero and SCLK low, ready for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first single-slave SPI master with a guard gap between frames.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int GUARD   = DEF_GUARD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_bit,
  input  logic [DATA_W-1:0] input_data,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SS,
  output logic              internal_clk,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              busy
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int GRD_W = $clog2(GUARD + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD - 1);

  spi_state_e        state, state_next;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GRD_W-1:0]  grd_cnt;
  logic              mosi_q;
  logic              done_q;
  logic              sclk;
  logic              rise_pulse;
  logic              fall_pulse;
  logic              frame_end;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state == ST_SHIFT),
    .sclk       (sclk),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  assign frame_end = fall_pulse && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_bit)            state_next = ST_SHIFT;
      ST_SHIFT: if (frame_end)            state_next = ST_GUARD;
      ST_GUARD: if (grd_cnt == GRD_LAST)  state_next = ST_IDLE;
      default:                            state_next = ST_IDLE;
    endcase
  end

  // Control and visible outputs; done is a single-cycle strobe by default-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      grd_cnt <= '0;
      mosi_q  <= 1'b0;
      rx_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_bit) begin
            mosi_q  <= input_data[DATA_W-1];
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (frame_end) begin
            mosi_q  <= 1'b0;
            rx_q    <= rx_shift;
            done_q  <= 1'b1;
            grd_cnt <= '0;
          end else if (fall_pulse) begin
            mosi_q  <= tx_shift[DATA_W-2];
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_GUARD: grd_cnt <= grd_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Shift registers carry data only; every frame fully overwrites them.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start_bit)
      tx_shift <= input_data;
    else if (state == ST_SHIFT && fall_pulse)
      tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
    if (state == ST_SHIFT && rise_pulse)
      rx_shift <= {rx_shift[DATA_W-2:0], MISO};
  end

  assign SS           = (state != ST_SHIFT);
  assign busy         = (state != ST_IDLE);
  assign MOSI         = mosi_q;
  assign internal_clk = sclk;
  assign rx_data      = rx_q;
  assign done         = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: default 8-bit instance plus a 16-bit, CLK_DIV=2 instance.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [7:0]  data0 = '0;
  logic [15:0] data1 = '0;
  logic        miso0, miso1, mosi0, mosi1, ss0, ss1, sclk0, sclk1;
  logic        done0, done1, busy0, busy1;
  logic [7:0]  rx0;
  logic [15:0] rx1;

  logic [7:0]  slave0 = '0;
  logic [15:0] slave1 = '0;
  logic        loopback = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  idx0 = 4'd7, idx1 = 4'd15;
  logic        prev_s0 = 1'b0, prev_s1 = 1'b0;

  logic        ss_m, sclk_m, mosi_m, done_m, busy_m;
  logic [15:0] rx_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_bit(start0), .input_data(data0), .MISO(miso0),
    .MOSI(mosi0), .SS(ss0), .internal_clk(sclk0), .rx_data(rx0), .done(done0), .busy(busy0)
  );

  spi_master #(.DATA_W(16), .CLK_DIV(2), .GUARD(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_bit(start1), .input_data(data1), .MISO(miso1),
    .MOSI(mosi1), .SS(ss1), .internal_clk(sclk1), .rx_data(rx1), .done(done1), .busy(busy1)
  );

  // Slave model: presents its byte MSB first, moving to the next bit after each SCLK fall.
  always @(negedge clk) begin
    if (ss0) idx0 <= 4'd7;
    else if (prev_s0 && !sclk0 && idx0 != 0) idx0 <= idx0 - 4'd1;
    prev_s0 <= sclk0;
    if (ss1) idx1 <= 4'd15;
    else if (prev_s1 && !sclk1 && idx1 != 0) idx1 <= idx1 - 4'd1;
    prev_s1 <= sclk1;
  end

  always_comb begin
    miso0  = loopback ? mosi0 : slave0[idx0[2:0]];
    miso1  = slave1[idx1];
    ss_m   = sel ? ss1   : ss0;
    sclk_m = sel ? sclk1 : sclk0;
    mosi_m = sel ? mosi1 : mosi0;
    done_m = sel ? done1 : done0;
    busy_m = sel ? busy1 : busy0;
    rx_m   = sel ? rx1   : {8'h00, rx0};
  end

  // Observes one frame on the selected instance, sampling at the falling clk edge.
  task automatic capture(input int chg_at, input logic [15:0] chg_val,
                         output logic [15:0] mw, output int ss_low, output int pulses,
                         output int dones, output int hi, output int busy_bad,
                         output logic [15:0] rx, output bit ok);
    logic prev;
    int n;
    mw = '0; ss_low = 0; pulses = 0; dones = 0; hi = 0; busy_bad = 0; rx = '0;
    ok = 1'b1; prev = 1'b0; n = 0;
    while (ss_m && hi < 3000) begin
      @(negedge clk);
      hi++;
    end
    if (ss_m) begin
      ok = 1'b0;
      return;
    end
    while (!ss_m && n < 3000) begin
      ss_low++;
      if (sclk_m && !prev) begin
        mw = {mw[14:0], mosi_m};
        pulses++;
      end
      prev = sclk_m;
      if (done_m) dones++;
      if (!busy_m) busy_bad++;
      if (ss_low == chg_at) begin
        if (sel) data1 = chg_val;
        else     data0 = chg_val[7:0];
      end
      @(negedge clk);
      n++;
    end
    if (!ss_m) ok = 1'b0;
    if (done_m) dones++;
    rx = rx_m;
  endtask

  task automatic pulse_start(input logic which);
    @(negedge clk);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    int dn;
    bad = 0;
    start0 = 1'b1; start1 = 1'b1; data0 = 8'h5A; data1 = 16'h1234;
    #1 rst_n = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ss0 !== 1'b1 || mosi0 !== 1'b0 || sclk0 !== 1'b0 || done0 !== 1'b0 ||
          busy0 !== 1'b0 || rx0 !== 8'h00 || ss1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_hold: %0d cycles with outputs off their reset values, required 0", bad);
    end
    start0 = 1'b0; start1 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    sel = 1'b0;
    data0 = 8'h32; slave0 = 8'hC3;
    pulse_start(1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (ss0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_midframe_setup: ss=%b busy=%b, required ss=0 busy=1", ss0, busy0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ss0, sclk0, busy0, mosi0, done0} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_midframe_abort: ss,sclk,busy,mosi,done=%b, required 10000",
               {ss0, sclk0, busy0, mosi0, done0});
    end
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done0) dn++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done0 || !ss0) dn++;
    end
    checks++;
    if (dn !== 0 || rx0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_no_done: stray done/ss-low cycles=%0d rx=%h, required 0 and 00", dn, rx0);
    end
  endtask

  task automatic test_idle;
    int bad;
    bad = 0;
    start0 = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (sclk0 !== 1'b0 || ss0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d active cycles while idle, required 0", bad);
    end
  endtask

  task automatic test_single_frame;
    logic [15:0] mw, rx;
    int ss_low, pulses, dones, hi, bb;
    bit ok;
    sel = 1'b0;
    data0 = 8'h32; slave0 = 8'hA5;
    pulse_start(1'b0);
    capture(-1, 16'h0, mw, ss_low, pulses, dones, hi, bb, rx, ok);
    checks++;
    if (!ok || mw[7:0] !== 8'h32 || pulses !== 8 || ss_low !== 64) begin
      errors++;
      $display("FAIL single_shape: ok=%0d mosi=%h pulses=%0d ss_low=%0d, required 1 32 8 64",
               ok, mw[7:0], pulses, ss_low);
    end
    checks++;
    if (dones !== 1 || rx[7:0] !== 8'hA5 || bb !== 0) begin
      errors++;
      $display("FAIL single_result: dones=%0d rx=%h busy_low=%0d, required 1 A5 0", dones, rx[7:0], bb);
    end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || sclk0 !== 1'b0 || mosi0 !== 1'b0) begin
      errors++;
      $display("FAIL single_after: done=%b sclk=%b mosi=%b, required 0 0 0", done0, sclk0, mosi0);
    end
  endtask

  task automatic test_random_frames;
    logic [15:0] mw, rx;
    logic [7:0] d, s;
    int ss_low, pulses, dones, hi, bb;
    bit ok;
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (5) @(negedge clk);
      d = 8'($urandom_range(0, 255));
      s = 8'($urandom_range(0, 255));
      data0 = d; slave0 = s;
      pulse_start(1'b0);
      capture(-1, 16'h0, mw, ss_low, pulses, dones, hi, bb, rx, ok);
      checks++;
      if (!ok || mw[7:0] !== d || rx[7:0] !== s || pulses !== 8 || ss_low !== 64 || dones !== 1) begin
        errors++;
        $display("FAIL random_%0d: mosi=%h rx=%h pulses=%0d ss_low=%0d dones=%0d, required %h %h 8 64 1",
                 i, mw[7:0], rx[7:0], pulses, ss_low, dones, d, s);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] mw1, rxa, mw2, rxb;
    logic [7:0] s1, s2;
    int l1, p1, d1, h1, b1, l2, p2, d2, h2, b2;
    bit ok1, ok2;
    sel = 1'b0;
    repeat (5) @(negedge clk);
    s1 = 8'($urandom_range(0, 255));
    s2 = 8'($urandom_range(0, 255));
    slave0 = s1; data0 = 8'h32;
    start0 = 1'b1;
    capture(30, 16'h00AA, mw1, l1, p1, d1, h1, b1, rxa, ok1);
    slave0 = s2;
    capture(-1, 16'h0, mw2, l2, p2, d2, h2, b2, rxb, ok2);
    start0 = 1'b0;
    checks++;
    if (!ok1 || mw1[7:0] !== 8'h32 || rxa[7:0] !== s1 || l1 !== 64) begin
      errors++;
      $display("FAIL b2b_first: mosi=%h rx=%h ss_low=%0d, required 32 %h 64", mw1[7:0], rxa[7:0], l1, s1);
    end
    checks++;
    if (!ok2 || mw2[7:0] !== 8'hAA || rxb[7:0] !== s2 || l2 !== 64 || d2 !== 1) begin
      errors++;
      $display("FAIL b2b_second: mosi=%h rx=%h ss_low=%0d dones=%0d, required AA %h 64 1",
               mw2[7:0], rxb[7:0], l2, d2, s2);
    end
    checks++;
    if (h2 !== 3) begin
      errors++;
      $display("FAIL b2b_gap: ss high for %0d cycles, required 3", h2);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_loopback;
    logic [15:0] mw, rx;
    int ss_low, pulses, dones, hi, bb;
    bit ok;
    logic [7:0] pat [2];
    pat[0] = 8'hFF; pat[1] = 8'h00;
    sel = 1'b0;
    loopback = 1'b1;
    for (int i = 0; i < 2; i++) begin
      repeat (5) @(negedge clk);
      data0 = pat[i];
      pulse_start(1'b0);
      capture(-1, 16'h0, mw, ss_low, pulses, dones, hi, bb, rx, ok);
      checks++;
      if (!ok || rx[7:0] !== pat[i] || rx0 !== pat[i]) begin
        errors++;
        $display("FAIL loopback_%0d: rx=%h rx_data=%h, required %h", i, rx[7:0], rx0, pat[i]);
      end
    end
    loopback = 1'b0;
  endtask

  task automatic test_param_sweep;
    logic [15:0] mw, rx, s;
    int ss_low, pulses, dones, hi, bb;
    bit ok;
    sel = 1'b1;
    repeat (5) @(negedge clk);
    s = 16'($urandom_range(0, 65535));
    slave1 = s; data1 = 16'h8001;
    pulse_start(1'b1);
    capture(-1, 16'h0, mw, ss_low, pulses, dones, hi, bb, rx, ok);
    checks++;
    if (!ok || ss_low !== 64 || pulses !== 16 || mw !== 16'h8001) begin
      errors++;
      $display("FAIL sweep_shape: ss_low=%0d pulses=%0d mosi=%h, required 64 16 8001", ss_low, pulses, mw);
    end
    checks++;
    if (rx !== s || dones !== 1) begin
      errors++;
      $display("FAIL sweep_result: rx=%h dones=%0d, required %h 1", rx, dones, s);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_frame();
    test_random_frames();
    test_back_to_back();
    test_loopback();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
